// File: rtl/dmg_fb_pkg.sv
// Shared constants and types for the double-buffered framebuffer arbiter.
package dmg_fb_pkg;

  localparam int FB_AW    = 13;
  localparam int FB_DW    = 8;
  localparam int FB_BYTES = 5760;

  typedef enum logic [0:0] {
    SW_IDLE    = 1'b0,
    SW_PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/dmg_fb_wfifo.sv
// Small synchronous FIFO buffering writer bytes until the RAM port is idle.
module dmg_fb_wfifo
  import dmg_fb_pkg::*;
#(
  parameter int W     = FB_AW + FB_DW,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wptr;
  logic [PW:0]  rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-1:0]] <= push_data;
  end

  // Extra pointer bit distinguishes full from empty when indices match.
  assign head  = mem[rptr[PW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

endmodule

// File: rtl/dmg_fb_arbiter.sv
// Single-port RAM arbiter: scan-out reads win, queued writes fill idle cycles,
// and bank swaps wait for the LCD frame boundary.
module dmg_fb_arbiter
  import dmg_fb_pkg::*;
#(
  parameter int AW         = FB_AW,
  parameter int DW         = FB_DW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_8m,
  input  logic          rst,
  input  logic          newframe,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_frame_done,
  output logic [AW:0]   mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          front_bank,
  output logic          swap_pending,
  output logic          swap_done
);

  swap_state_t      state;
  swap_state_t      state_next;
  logic [AW+DW-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             issue;
  logic             swap_go;
  logic [1:0]       rd_pipe;

  assign push         = wr_valid && wr_ready;
  assign issue        = !rd_req && !empty;
  assign swap_pending = (state == SW_PENDING);
  assign wr_ready     = !rst && !full && !swap_pending;

  dmg_fb_wfifo #(
    .W     (AW + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk       (clk_8m),
    .rst       (rst),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (issue),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) state <= SW_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SW_IDLE: begin
        if (wr_frame_done) state_next = SW_PENDING;
        else               state_next = SW_IDLE;
      end
      SW_PENDING: begin
        if (swap_go) state_next = SW_IDLE;
        else         state_next = SW_PENDING;
      end
      default: state_next = SW_IDLE;
    endcase
  end

  // Swap only once every queued byte has reached the back bank.
  always_comb begin
    swap_go = 1'b0;
    case (state)
      SW_PENDING: begin
        if (newframe && empty && !issue) swap_go = 1'b1;
        else                             swap_go = 1'b0;
      end
      default: swap_go = 1'b0;
    endcase
  end

  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      front_bank <= 1'b0;
      swap_done  <= 1'b0;
    end else begin
      swap_done <= swap_go;
      if (swap_go) front_bank <= ~front_bank;
    end
  end

  // Port mux: the bank is captured into the address MSB at acceptance.
  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= issue;
      if (rd_req) begin
        mem_addr <= {front_bank, rd_addr};
      end else if (issue) begin
        mem_addr  <= {~front_bank, head[AW+DW-1:DW]};
        mem_wdata <= head[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      rd_pipe  <= 2'b00;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pipe  <= {rd_pipe[0], rd_req};
      rd_valid <= rd_pipe[1];
      if (rd_pipe[1]) rd_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmg_fb_arbiter.sv
// Directed self-checking bench for dmg_fb_arbiter with a behavioural sync RAM.
module tb_dmg_fb_arbiter;
  import dmg_fb_pkg::*;

  localparam int AW    = FB_AW;
  localparam int DW    = FB_DW;
  localparam int WORDS = 1 << (AW + 1);

  logic          clk_8m = 1'b0;
  logic          rst;
  logic          newframe;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_frame_done;
  logic [AW:0]   mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          front_bank;
  logic          swap_pending;
  logic          swap_done;

  logic [DW-1:0] ram [WORDS];
  logic          preload;
  logic          rd_prev = 1'b0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            we_cnt = 0;
  int            base;
  int            acc;
  logic [7:0]    drain_data [3] = '{8'hA5, 8'h5A, 8'hFF};

  dmg_fb_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(4)) dut (
    .clk_8m        (clk_8m),
    .rst           (rst),
    .newframe      (newframe),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_frame_done (wr_frame_done),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .front_bank    (front_bank),
    .swap_pending  (swap_pending),
    .swap_done     (swap_done)
  );

  always #5 clk_8m = ~clk_8m;

  // Bank 0 holds the low address byte, bank 1 its complement.
  function automatic logic [7:0] init_byte(input int a);
    logic [13:0] aa;
    aa = a[13:0];
    return aa[13] ? (aa[7:0] ^ 8'hFF) : aa[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_8m);
    #1;
  endtask

  always @(posedge clk_8m) begin
    if (preload) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_byte(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  always @(posedge clk_8m) rd_prev <= rd_req;

  always @(negedge clk_8m) begin
    if (mem_we) begin
      we_cnt++;
      chk("we_not_in_rd_cycle", 32'(rd_prev), 32'd0);
    end
  end

  initial begin
    rst = 1'b1; preload = 1'b1;
    newframe = 1'b0; rd_req = 1'b0; rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_frame_done = 1'b0;
    tick;
    preload = 1'b0;
    tick;

    chk("rst_front_bank", 32'(front_bank), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_swap_pending", 32'(swap_pending), 32'd0);
    chk("rst_swap_done", 32'(swap_done), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

    // Read latency: 10 back-to-back requests.
    for (int c = 0; c < 13; c++) begin
      rd_req  = (c < 10);
      rd_addr = c[AW-1:0];
      tick;
      if (c + 1 == 1) chk("rd_mem_addr_first", 32'(mem_addr), 32'd0);
      chk("rd_valid_latency", 32'(rd_valid), ((c + 1 >= 3) && (c + 1 <= 12)) ? 32'd1 : 32'd0);
      if ((c + 1 >= 3) && (c + 1 <= 12)) chk("rd_data_seq", 32'(rd_data), 32'(init_byte(c - 2)));
      if (c + 1 == 13) chk("rd_data_hold", 32'(rd_data), 32'(init_byte(9)));
    end

    // Last byte of a bank.
    rd_req = 1'b1; rd_addr = 13'(FB_BYTES - 1);
    tick; rd_req = 1'b0;
    tick; tick;
    chk("rd_last_valid", 32'(rd_valid), 32'd1);
    chk("rd_last_data", 32'(rd_data), 32'h7F);
    tick;

    // Write drain with no reads.
    base = we_cnt;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 13'(16 + i); wr_data = drain_data[i];
      chk("drain_wr_ready", 32'(wr_ready), 32'd1);
      tick;
    end
    wr_valid = 1'b0;
    repeat (5) tick;
    chk("drain_we_count", 32'(we_cnt - base), 32'd3);
    for (int i = 0; i < 3; i++) chk("drain_ram", 32'(ram[8192 + 16 + i]), 32'(drain_data[i]));

    // Back-pressure under continuous reads.
    base = we_cnt; acc = 0;
    rd_req = 1'b1; rd_addr = '0;
    for (int j = 0; j < 8; j++) begin
      wr_valid = 1'b1; wr_addr = 13'(32 + acc); wr_data = 8'(48 + acc);
      chk("bp_wr_ready", 32'(wr_ready), (j < 4) ? 32'd1 : 32'd0);
      if (wr_ready) acc++;
      tick;
    end
    chk("bp_accepts_blocked", 32'(acc), 32'd4);
    chk("bp_no_write_during_reads", 32'(we_cnt - base), 32'd0);
    rd_req = 1'b0;
    for (int j = 0; j < 12; j++) begin
      wr_valid = (acc < 6); wr_addr = 13'(32 + acc); wr_data = 8'(48 + acc);
      if (wr_valid && wr_ready) acc++;
      tick;
    end
    wr_valid = 1'b0;
    chk("bp_accepts_total", 32'(acc), 32'd6);
    chk("bp_we_count", 32'(we_cnt - base), 32'd6);
    for (int i = 0; i < 6; i++) chk("bp_ram", 32'(ram[8192 + 32 + i]), 32'(48 + i));

    // Swap with an empty FIFO.
    wr_frame_done = 1'b1; tick; wr_frame_done = 1'b0;
    chk("swap_pending_set", 32'(swap_pending), 32'd1);
    chk("swap_wr_ready_low", 32'(wr_ready), 32'd0);
    chk("swap_front_old", 32'(front_bank), 32'd0);
    repeat (19) tick;
    chk("swap_pending_wait", 32'(swap_pending), 32'd1);
    newframe = 1'b1; rd_req = 1'b1; rd_addr = 13'd5;
    tick;
    newframe = 1'b0; rd_req = 1'b1; rd_addr = 13'd6;
    chk("swap_done_pulse", 32'(swap_done), 32'd1);
    chk("swap_front_new", 32'(front_bank), 32'd1);
    chk("swap_pending_clr", 32'(swap_pending), 32'd0);
    chk("swap_old_bank_addr", 32'(mem_addr), 32'h0005);
    chk("swap_wr_ready_back", 32'(wr_ready), 32'd1);
    tick;
    rd_req = 1'b0;
    chk("swap_done_one_cycle", 32'(swap_done), 32'd0);
    chk("swap_new_bank_addr", 32'(mem_addr), 32'h2006);
    tick;
    chk("swap_rd_old_valid", 32'(rd_valid), 32'd1);
    chk("swap_rd_old_data", 32'(rd_data), 32'(init_byte(5)));
    tick;
    chk("swap_rd_new_valid", 32'(rd_valid), 32'd1);
    chk("swap_rd_new_data", 32'(rd_data), 32'(init_byte(32'h2006)));
    tick;

    // Deferred swap: coincident done/newframe, then newframe with 2 queued.
    rd_req = 1'b1; rd_addr = '0;
    wr_valid = 1'b1; wr_addr = 13'h40; wr_data = 8'h11;
    chk("def_push0_ready", 32'(wr_ready), 32'd1);
    tick;
    wr_addr = 13'h41; wr_data = 8'h22;
    chk("def_push1_ready", 32'(wr_ready), 32'd1);
    tick;
    wr_valid = 1'b0; wr_frame_done = 1'b1; newframe = 1'b1;
    tick;
    wr_frame_done = 1'b0;
    chk("def_pending", 32'(swap_pending), 32'd1);
    chk("def_no_swap1", 32'(swap_done), 32'd0);
    chk("def_front1", 32'(front_bank), 32'd1);
    chk("def_wr_ready1", 32'(wr_ready), 32'd0);
    tick;
    newframe = 1'b0;
    chk("def_no_swap2", 32'(swap_done), 32'd0);
    chk("def_front2", 32'(front_bank), 32'd1);
    chk("def_pending2", 32'(swap_pending), 32'd1);
    rd_req = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick;
      chk("def_wr_ready_pending", 32'(wr_ready), 32'd0);
      chk("def_no_swap_drain", 32'(swap_done), 32'd0);
    end
    chk("def_ram0", 32'(ram[16'h0040]), 32'h11);
    chk("def_ram1", 32'(ram[16'h0041]), 32'h22);
    newframe = 1'b1; tick; newframe = 1'b0;
    chk("def_swap3", 32'(swap_done), 32'd1);
    chk("def_front3", 32'(front_bank), 32'd0);
    chk("def_pending3", 32'(swap_pending), 32'd0);
    chk("def_wr_ready3", 32'(wr_ready), 32'd1);
    tick;

    // Reset mid-read with a queued write and front_bank=1.
    wr_frame_done = 1'b1; tick; wr_frame_done = 1'b0;
    newframe = 1'b1; tick; newframe = 1'b0;
    chk("mr_front_pre", 32'(front_bank), 32'd1);
    rd_req = 1'b1; rd_addr = 13'd3;
    wr_valid = 1'b1; wr_addr = 13'h50; wr_data = 8'h77;
    tick;
    wr_valid = 1'b0; rd_addr = 13'd4;
    tick;
    rd_req = 1'b0; rst = 1'b1;
    #1;
    chk("mr_rd_valid_rst", 32'(rd_valid), 32'd0);
    chk("mr_front_rst", 32'(front_bank), 32'd0);
    chk("mr_mem_we_rst", 32'(mem_we), 32'd0);
    chk("mr_wr_ready_rst", 32'(wr_ready), 32'd0);
    chk("mr_pending_rst", 32'(swap_pending), 32'd0);
    tick;
    rst = 1'b0;
    base = we_cnt;
    for (int j = 0; j < 6; j++) begin
      tick;
      chk("mr_no_rd_valid", 32'(rd_valid), 32'd0);
    end
    chk("mr_fifo_empty_no_we", 32'(we_cnt - base), 32'd0);
    chk("mr_wr_ready_after", 32'(wr_ready), 32'd1);
    chk("mr_ram_untouched", 32'(ram[16'h0050]), 32'(init_byte(32'h50)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
